// File: rtl/seg_scanner_if.sv
// Bundle of per-digit cathode patterns, enable and scanned display outputs
// shared between the game top level and the seven-segment scanner.
interface seg_scanner_if;
   logic [7:0] seg0;
   logic [7:0] seg1;
   logic [7:0] seg2;
   logic [7:0] seg3;
   logic       dispEn;
   logic [3:0] an;
   logic [7:0] segOut;
   logic       frameTick;

   modport master (
      output seg0, seg1, seg2, seg3, dispEn,
      input  an, segOut, frameTick
   );

   modport slave (
      input  seg0, seg1, seg2, seg3, dispEn,
      output an, segOut, frameTick
   );
endinterface

// File: rtl/seg_scanner.sv
// Time-multiplexed 4-digit common-anode seven-segment scanner with per-slot
// blanking and whole-frame snapshot of the digit patterns.
module seg_scanner #(
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic         Clk100M,
   input  logic         reset,
   seg_scanner_if.slave bus
);

   localparam int                CNT_W = $clog2(REFRESH_DIV);
   localparam logic [CNT_W-1:0]  LAST  = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0]  BLANK = CNT_W'(BLANK_CYCLES);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       dig_q, dig_d;
   logic [3:0][7:0]  snap_q, snap_d;
   logic [3:0]       an_q, an_d;
   logic [7:0]       seg_q, seg_d;
   logic             ft_q, ft_d;
   logic             capture;
   logic             lit;

   always_comb begin
      capture = (cnt_q == '0) && (dig_q == 2'd0);
      lit     = bus.dispEn && (cnt_q >= BLANK);

      cnt_d = cnt_q + CNT_W'(1);
      dig_d = dig_q;
      if (cnt_q == LAST) begin
         cnt_d = '0;
         dig_d = dig_q + 2'd1;
      end

      // All four patterns are latched together so a frame is never mixed.
      snap_d = snap_q;
      if (capture) begin
         snap_d = {bus.seg3, bus.seg2, bus.seg1, bus.seg0};
      end

      an_d  = 4'b1111;
      seg_d = 8'hFF;
      if (lit) begin
         an_d  = ~(4'b0001 << dig_q);
         seg_d = snap_q[dig_q];
      end
      ft_d = capture;
   end

   always_ff @(posedge Clk100M or posedge reset) begin
      if (reset) begin
         cnt_q  <= '0;
         dig_q  <= 2'd0;
         snap_q <= {4{8'hFF}};
         an_q   <= 4'b1111;
         seg_q  <= 8'hFF;
         ft_q   <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         dig_q  <= dig_d;
         snap_q <= snap_d;
         an_q   <= an_d;
         seg_q  <= seg_d;
         ft_q   <= ft_d;
      end
   end

   assign bus.an        = an_q;
   assign bus.segOut    = seg_q;
   assign bus.frameTick = ft_q;

endmodule

// File: tb/tb_seg_scanner.sv
// Bench for seg_scanner: two instances (short and long blanking) checked
// against a frame/slot timing model derived from edge numbers.
module tb_seg_scanner;

   localparam int RD    = 10;
   localparam int BL_A  = 2;
   localparam int BL_B  = 9;
   localparam int FRAME = 4 * RD;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] segv [4];
   logic       en;

   seg_scanner_if ifa ();
   seg_scanner_if ifb ();

   assign ifa.seg0 = segv[0];
   assign ifa.seg1 = segv[1];
   assign ifa.seg2 = segv[2];
   assign ifa.seg3 = segv[3];
   assign ifa.dispEn = en;
   assign ifb.seg0 = segv[0];
   assign ifb.seg1 = segv[1];
   assign ifb.seg2 = segv[2];
   assign ifb.seg3 = segv[3];
   assign ifb.dispEn = en;

   seg_scanner #(.REFRESH_DIV(RD), .BLANK_CYCLES(BL_A)) dut_a (
      .Clk100M (clk),
      .reset   (rst),
      .bus     (ifa)
   );

   seg_scanner #(.REFRESH_DIV(RD), .BLANK_CYCLES(BL_B)) dut_b (
      .Clk100M (clk),
      .reset   (rst),
      .bus     (ifb)
   );

   always #5 clk = ~clk;

   int         n_vec = 0;
   int         n_err = 0;
   int         k     = 0;
   int         nb    = 0;
   bit         slot_check = 1'b0;
   logic [7:0] msnap [4];
   logic [3:0] prev_a, prev_b;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] exp_an(input bit lit, input int d);
      logic [3:0] r;
      r = 4'hF;
      if (lit) r[d] = 1'b0;
      return r;
   endfunction

   // One clock edge: model the edge from pre-edge inputs, then compare.
   task automatic step();
      logic [7:0] pre [4];
      logic       pre_en;
      int         ph, d, c;
      bit         lit_a, lit_b;
      pre    = segv;
      pre_en = en;
      @(posedge clk);
      ph = k % FRAME;
      k++;
      if (ph == 0) msnap = pre;
      d = ph / RD;
      c = ph % RD;
      lit_a = pre_en && (c >= BL_A);
      lit_b = pre_en && (c >= BL_B);
      #1;
      chk("an_a",  ifa.an,        exp_an(lit_a, d));
      chk("seg_a", ifa.segOut,    lit_a ? msnap[d] : 8'hFF);
      chk("ft_a",  ifa.frameTick, (ph == 0));
      chk("an_b",  ifb.an,        exp_an(lit_b, d));
      chk("seg_b", ifb.segOut,    lit_b ? msnap[d] : 8'hFF);
      chk("ft_b",  ifb.frameTick, (ph == 0));
      chk("onehot_a", ($countones(~ifa.an) <= 1), 1);
      chk("onehot_b", ($countones(~ifb.an) <= 1), 1);
      if (prev_a != 4'hF && ifa.an != 4'hF) chk("nohop_a", ifa.an, prev_a);
      if (prev_b != 4'hF && ifb.an != 4'hF) chk("nohop_b", ifb.an, prev_b);
      prev_a = ifa.an;
      prev_b = ifb.an;
      if (ifb.an != 4'hF) nb++;
      if (c == RD - 1) begin
         if (slot_check) chk("lit_per_slot_b", nb, 1);
         nb = 0;
      end
   endtask

   task automatic do_reset();
      #2 rst = 1'b1;
      #1;
      chk("rst_an_a",  ifa.an,        4'hF);
      chk("rst_seg_a", ifa.segOut,    8'hFF);
      chk("rst_ft_a",  ifa.frameTick, 1'b0);
      chk("rst_an_b",  ifb.an,        4'hF);
      chk("rst_seg_b", ifb.segOut,    8'hFF);
      @(posedge clk);
      @(posedge clk);
      #3 rst = 1'b0;
      k      = 0;
      nb     = 0;
      prev_a = 4'hF;
      prev_b = 4'hF;
   endtask

   initial begin
      segv = '{8'hC0, 8'hF9, 8'hA4, 8'hB0};
      en   = 1'b1;
      do_reset();

      // Basic scan, snapshot isolation, dispEn and frameTick over 100 edges.
      repeat (3) step();
      chk("basic_an_e3",  ifa.an,     4'hE);
      chk("basic_seg_e3", ifa.segOut, 8'hC0);
      step();
      segv[1] = 8'h99;
      repeat (9) step();
      chk("iso_an_e13",  ifa.an,     4'hD);
      chk("iso_seg_e13", ifa.segOut, 8'hF9);
      repeat (2) step();
      en = 1'b0;
      step();
      chk("en_off_an_e16",  ifa.an,     4'hF);
      chk("en_off_seg_e16", ifa.segOut, 8'hFF);
      repeat (8) step();
      en = 1'b1;
      step();
      chk("en_on_an_e25",  ifa.an,     4'hB);
      chk("en_on_seg_e25", ifa.segOut, 8'hA4);
      repeat (28) step();
      chk("iso_seg_e53", ifa.segOut, 8'h99);
      repeat (47) step();

      // Mid-slot asynchronous reset, then the schedule restarts from edge 1.
      do_reset();
      segv[1] = 8'hF9;
      repeat (26) step();
      do_reset();
      repeat (3) step();
      chk("rerun_an_e3",  ifa.an,     4'hE);
      chk("rerun_seg_e3", ifa.segOut, 8'hC0);
      repeat (37) step();

      // Ten frames of random patterns with slot-aligned lit-time counting.
      do_reset();
      slot_check = 1'b1;
      for (int i = 0; i < 10 * FRAME; i++) begin
         for (int j = 0; j < 4; j++) segv[j] = 8'($urandom);
         step();
      end
      slot_check = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
